// File: rtl/siso_pkg.sv
// siso_pkg: shared constants and types for the serial-in serial-out delay line.
`timescale 1ns/1ps

package siso_pkg;

    localparam int DEPTH_DEFAULT = 4;
    localparam int WIDTH_DEFAULT = 1;
    localparam int DEPTH_MAX     = 64;

    // One lane word at the default width.
    typedef logic [WIDTH_DEFAULT-1:0] lane_t;

endpackage : siso_pkg

// File: rtl/siso_stage.sv
// siso_stage: a single WIDTH-bit delay flop with synchronous reset to RST_VAL.
`timescale 1ns/1ps

module siso_stage
    import siso_pkg::*;
#(
    parameter int               WIDTH   = WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d every edge; synchronous reset wins over data.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every stage samples its neighbour's
        // pre-edge value; blocking here would collapse the chain into one flop.
        if (rst) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule : siso_stage

// File: rtl/siso_shift_register.sv
// siso_shift_register: DEPTH-stage serial delay line, WIDTH bits per stage.
// Optional macro SISO_TAPS_EN adds a registered parallel view of all stages
// on port taps; without it the port and its wiring are absent.
`timescale 1ns/1ps

module siso_shift_register
    import siso_pkg::*;
#(
    parameter int               DEPTH   = DEPTH_DEFAULT,
    parameter int               WIDTH   = WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       si,
    output logic [WIDTH-1:0]       so
`ifdef SISO_TAPS_EN
    ,
    output logic [DEPTH*WIDTH-1:0] taps
`endif
);

    // Reject illegal depths when the design is elaborated.
    if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("siso_shift_register: DEPTH=%0d outside 1..%0d", DEPTH, DEPTH_MAX);
    end

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Chain of stages: stage 0 takes si, every later stage takes its predecessor.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] stage_d;

        if (i == 0) begin : g_head
            assign stage_d = si;
        end else begin : g_body
            assign stage_d = stage_q[i-1];
        end

        siso_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .d   (stage_d),
            .q   (stage_q[i])
        );

`ifdef SISO_TAPS_EN
        assign taps[i*WIDTH +: WIDTH] = stage_q[i];
`endif
    end

    // Output comes straight from the last flop; no path from si.
    assign so = stage_q[DEPTH-1];

endmodule : siso_shift_register

// File: tb/tb_siso_shift_register.sv
// tb_siso_shift_register: scoreboard bench for the serial delay line.
// Covers the default instance, a RST_VAL=1 instance and a DEPTH=1/WIDTH=8 one;
// taps are checked when SISO_TAPS_EN is defined.
`timescale 1ns/1ps

module tb_siso_shift_register;
    import siso_pkg::*;

    localparam int MAIN_DEPTH = 4;

    logic clk;

    // Default instance: DEPTH=4, WIDTH=1, RST_VAL=0.
    logic  rst_m;
    lane_t si_m;
    lane_t so_m;
    // RST_VAL=1 instance.
    logic  rst_r;
    lane_t si_r;
    lane_t so_r;
    // Degenerate instance: DEPTH=1, WIDTH=8.
    logic       rst_d;
    logic [7:0] si_d;
    logic [7:0] so_d;
`ifdef SISO_TAPS_EN
    logic [3:0] taps_m;
    logic [3:0] taps_r;
    logic [7:0] taps_d;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic sb_q [$];

    siso_shift_register #(.DEPTH(MAIN_DEPTH), .WIDTH(1), .RST_VAL(1'b0)) dut_main (
        .clk (clk),
        .rst (rst_m),
        .si  (si_m),
        .so  (so_m)
`ifdef SISO_TAPS_EN
        , .taps (taps_m)
`endif
    );

    siso_shift_register #(.DEPTH(4), .WIDTH(1), .RST_VAL(1'b1)) dut_rv1 (
        .clk (clk),
        .rst (rst_r),
        .si  (si_r),
        .so  (so_r)
`ifdef SISO_TAPS_EN
        , .taps (taps_r)
`endif
    );

    siso_shift_register #(.DEPTH(1), .WIDTH(8), .RST_VAL(8'h00)) dut_d1 (
        .clk (clk),
        .rst (rst_d),
        .si  (si_d),
        .so  (so_d)
`ifdef SISO_TAPS_EN
        , .taps (taps_d)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #100us;
        $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One edge on the default instance; the scoreboard supplies the expected so.
    task automatic tick_main(input string tag, input logic r, input logic s);
        logic exp;
        rst_m = r;
        si_m  = s;
        @(posedge clk);
        #1;
        if (r) begin
            sb_q.delete();
            for (int i = 0; i < MAIN_DEPTH - 1; i++) sb_q.push_back(1'b0);
            check({tag, "_rst"}, 64'(so_m), 64'(1'b0));
        end else begin
            sb_q.push_back(s);
            check({tag, "_sb_depth"}, 64'(sb_q.size()), 64'(MAIN_DEPTH));
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 1'bx;
            check(tag, 64'(so_m), 64'(exp));
        end
    endtask

    initial begin
        logic [3:0] pat;
        rst_m = 1'b1; si_m = 1'b0;
        rst_r = 1'b1; si_r = 1'b0;
        rst_d = 1'b1; si_d = 8'h00;

        // Basic shift: 1,0,0,1 then zeros.
        pat = 4'b1001;
        tick_main("t1", 1'b1, 1'b0);
        for (int i = 3; i >= 0; i--) tick_main("t1_shift", 1'b0, pat[i]);
`ifdef SISO_TAPS_EN
        check("t1_taps", 64'(taps_m), 64'(4'b1001));
`endif
        for (int i = 0; i < 4; i++) tick_main("t1_drain", 1'b0, 1'b0);

        // Reset mid-stream: three ones in flight, then reset discards them.
        for (int i = 0; i < 3; i++) tick_main("t3_fill", 1'b0, 1'b1);
        tick_main("t3", 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) tick_main("t3_after", 1'b0, 1'b0);

        // Continuous random stream plus flush.
        for (int i = 0; i < 32; i++) tick_main("t4_rand", 1'b0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < MAIN_DEPTH; i++) tick_main("t4_flush", 1'b0, 1'b0);

        // Reset value 1: held for 3 edges after deassert, then si appears.
        rst_r = 1'b1;
        @(posedge clk); #1;
        check("t2_rst", 64'(so_r), 64'(1'b1));
        rst_r = 1'b0;
        si_r  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("t2_hold", 64'(so_r), 64'(1'b1));
        end
        @(posedge clk); #1;
        check("t2_first_si", 64'(so_r), 64'(1'b0));

        // Degenerate depth: single flop, one-edge latency.
        rst_d = 1'b1;
        @(posedge clk); #1;
        check("t5_rst", 64'(so_d), 64'(8'h00));
        rst_d = 1'b0;
        si_d  = 8'hA5;
        @(posedge clk); #1;
        check("t5_a5", 64'(so_d), 64'(8'hA5));
        si_d  = 8'h3C;
        @(posedge clk); #1;
        check("t5_3c", 64'(so_d), 64'(8'h3C));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_siso_shift_register
